sd_cmd_engine: RTL and testbench
================================

# sd_cmd_engine

Parametrised SD command-line engine that replaces the separate one-width send and receive paths in the SD host controller. It generates SD_CLK from a runtime divider. It serialises 48-bit command frames with computed CRC7, then captures no, short or long (R2) responses with timeout, CRC, index and end-bit checking. It sits between `sd_fsm` and the `sd_cmd_pin` tri-state buffer, with a valid/ready command port and a one-cycle response strobe.

## Interface
- `DIV_W`, 16: width of the clock-divider input.
- `NCR_MAX`, 64: maximum number of SD_CLK cycles from the command end bit to the response start bit.
- `NCC`, 8: number of idle SD_CLK cycles inserted after each transaction.
- `ex_clk` in 1: single system clock.
- `ex_resetn` in 1: synchronous, active-low reset.
- `clk_div` in DIV_W: SD_CLK half-period equals `clk_div`+1 `ex_clk` cycles.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: engine idle and able to accept a command.
- `cmd_index` in 6: command number.
- `cmd_arg` in 32: command argument.
- `resp_type` in 2: 0 none, 1 short with CRC check, 2 short without CRC check (R3), 3 long (R2).
- `resp_valid` out 1: one-cycle pulse at the end of a transaction.
- `resp_data` out 127: short responses give {index, arg} in bits [37:0] with the upper bits zero; long responses give response bits [127:1].
- `resp_err` out 3: {index/end-bit error, CRC error, timeout}. Valid only with `resp_valid`.
- `sd_clk` out 1: card clock.
- `sd_cmd_out` out 1: CMD line drive value.
- `sd_cmd_oe` out 1: CMD line output enable (1 = drive).
- `sd_cmd_in` in 1: sampled CMD line.

## Operation
- **Clock generation:** the divider counter runs continuously. `sd_clk` toggles when the counter reaches `clk_div`, then the counter clears. A change to `clk_div` takes effect at the next wrap. The divider produces internal `rise_en` and `fall_en` strobes.
- **Acceptance:** a command is accepted when `cmd_valid` and `cmd_ready` are both high in the same cycle. On acceptance the engine latches `cmd_index`, `cmd_arg` and `resp_type`, and `cmd_ready` drops the next cycle.
- **States:** IDLE → SEND → (resp_type==0 ? GAP : WAIT) → RECV → GAP → IDLE.
- **SEND:** the frame is {0, 1, index, arg, CRC7, 1}. CRC7 uses polynomial x^7+x^3+1 over the first 40 bits. One bit is shifted out per `fall_en`, MSB first, with `sd_cmd_oe` high. After the end bit, `sd_cmd_oe` drops at the next `fall_en`.
- **WAIT:** `sd_cmd_in` is sampled on `rise_en`. A 0 moves the engine to RECV. If `NCR_MAX` rising edges pass without a start bit, the timeout bit is set and the engine goes to GAP with `resp_data` zero.
- **RECV:** the engine captures 47 more bits (short) or 135 more bits (long) on `rise_en`.
  - Short, type 1: check CRC over bits [47:8], check the returned index against the command index, and check that the end bit is 1.
  - Short, type 2: check only the end bit. The index field is ignored (R3 returns 111111).
  - Long: check CRC over `resp_data`[126:7] against [6:0], and check the end bit.
- **GAP:** the engine waits `NCC` rising edges, then pulses `resp_valid` for one cycle, and `cmd_ready` rises in the same cycle.
- **Busy handling:** `cmd_valid` while `cmd_ready`=0 is ignored and not queued.
- **Line sampling:** `sd_cmd_in` is sampled only on `rise_en`. Line glitches between edges have no effect.

## Timing
- **Reset values:** `sd_clk`=0, divider counter=0, `sd_cmd_out`=1, `sd_cmd_oe`=0, `cmd_ready`=1, `resp_valid`=0, `resp_data`=0, `resp_err`=0, state IDLE.
- **Reset mid-transaction:** on the next `ex_clk` the engine returns to reset values. There is no `resp_valid` for the aborted command.
- **Start-bit latency:** the start bit is driven at the first `fall_en` after acceptance.
- **Command duration:** the SEND phase takes exactly 48 SD_CLK periods.
- **Response latency:** `resp_valid` occurs `NCC` rising edges after the last response bit is sampled, plus one `ex_clk` cycle.
- **Divide-by-two:** with `clk_div`=0, `sd_clk` toggles every `ex_clk` cycle, so `rise_en` and `fall_en` alternate each cycle. The engine must function correctly at this setting.
- **Busy period:** `cmd_ready` stays low from the cycle after acceptance through the `resp_valid` cycle, exclusive of that cycle.
- **Error reporting:** `resp_err` bits are independent, and several can be set together (for example CRC and end-bit errors).

## Structure
- **Shared package `sd_pkg`:**
  - resp_type encodings
  - CRC7 polynomial 7'h09
  - frame lengths 48 and 136
  - `resp_err` bit positions
  - state encoding
- **Sub-module `sd_crc7`:** serial CRC with clear, enable and data-bit inputs and a 7-bit output. One instance is used for TX and one for RX checking.

## Test plan
- **CMD0, no response:** `cmd_index`=0, arg 0, type 0 → line carries 0x400000000095 MSB first. `resp_valid` occurs 8 SD_CLK cycles after the end bit, with `resp_err`=0.
- **CMD8, short response with CRC:** arg 0x1AA, type 1 → TX frame 0x48000001AA87. A card model replying 0x08000001AA13 gives `resp_data`[37:0]={8, 0x1AA} and `resp_err`=0.
- **Short response error injection:** same as the CMD8 case but flip one CRC bit → CRC error set. Separately, reply with index 9 → index error set.
- **Timeout:** type 1 with no start bit for 64 SD_CLK cycles → `resp_err`=3'b001 and `resp_data`=0.
- **Long response:** R2 with a known CID payload and a correct CRC7 → `resp_data` equals the payload and there is no error. `clk_div`=0 and `clk_div`=3 must give identical results.
- **Reset and busy handling:** assert `ex_resetn`=0 mid-SEND → `sd_cmd_oe`=0 and `cmd_ready`=1 on the next cycle, with no `resp_valid`. A `cmd_valid` pulse during a transaction is ignored.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line engine: response kinds,
// FSM states, frame lengths, error-bit positions and the CRC7 step function.
package sd_pkg;

    typedef enum logic [1:0] {
        RESP_NONE        = 2'd0,
        RESP_SHORT       = 2'd1,
        RESP_SHORT_NOCRC = 2'd2,
        RESP_LONG        = 2'd3
    } resp_type_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_GAP  = 3'd4
    } state_e;

    localparam logic [6:0]  CRC7_POLY = 7'h09;
    localparam int unsigned CMD_LEN   = 48;
    localparam int unsigned SHORT_LEN = 48;
    localparam int unsigned LONG_LEN  = 136;
    localparam int unsigned CRC_BITS  = 40;

    localparam int unsigned ERR_TIMEOUT = 0;
    localparam int unsigned ERR_CRC     = 1;
    localparam int unsigned ERR_IDX     = 2;

    function automatic logic [6:0] crc7_next(logic [6:0] crc, logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_cmd_engine_if.sv
// Command/response handshake between sd_fsm (master) and the command engine (slave).
interface sd_cmd_engine_if;

    logic         cmd_valid;
    logic         cmd_ready;
    logic [5:0]   cmd_index;
    logic [31:0]  cmd_arg;
    logic [1:0]   resp_type;
    logic         resp_valid;
    logic [126:0] resp_data;
    logic [2:0]   resp_err;

    modport master (
        output cmd_valid, cmd_index, cmd_arg, resp_type,
        input  cmd_ready, resp_valid, resp_data, resp_err
    );

    modport slave (
        input  cmd_valid, cmd_index, cmd_arg, resp_type,
        output cmd_ready, resp_valid, resp_data, resp_err
    );

endinterface

// File: rtl/sd_crc7.sv
// Bit-serial CRC7 (x^7 + x^3 + 1) with synchronous clear and enable.
module sd_crc7
    import sd_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [6:0] crc
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crc <= '0;
        end else if (clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc7_next(crc, din);
        end
    end

endmodule

// File: rtl/sd_cmd_engine.sv
// SD CMD-line engine: SD_CLK divider, 48-bit command serialiser with CRC7, and
// none/short/long response capture with timeout, CRC, index and end-bit checks.
module sd_cmd_engine
    import sd_pkg::*;
#(
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned NCR_MAX = 64,
    parameter int unsigned NCC     = 8
) (
    input  logic             ex_clk,
    input  logic             ex_resetn,
    input  logic [DIV_W-1:0] clk_div,
    sd_cmd_engine_if.slave   cmd,
    output logic             sd_clk,
    output logic             sd_cmd_out,
    output logic             sd_cmd_oe,
    input  logic             sd_cmd_in
);

    localparam int unsigned WAIT_W = $clog2(NCR_MAX + 1);
    localparam int unsigned GAP_W  = $clog2(NCC + 1);

    logic [DIV_W-1:0] div_cnt;
    logic             wrap, rise_en, fall_en;

    state_e       state, state_n;
    resp_type_e   type_q;
    logic [5:0]   idx_q;
    logic [39:0]  tx_sr;
    logic [126:0] rx_sr;
    logic [127:0] rx_next;
    logic [7:0]   bit_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic         accept, rx_last;
    logic         tx_crc_en, rx_crc_en;
    logic [6:0]   tx_crc, rx_crc;
    logic [2:0]   crc_idx;

    // ">=" so a clk_div lowered below the running count still wraps promptly.
    assign wrap    = (div_cnt >= clk_div);
    assign rise_en = wrap && !sd_clk;
    assign fall_en = wrap && sd_clk;

    always_ff @(posedge ex_clk) begin
        if (!ex_resetn) begin
            div_cnt <= '0;
            sd_clk  <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            sd_clk  <= ~sd_clk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign cmd.cmd_ready = (state == ST_IDLE);
    assign rx_next       = {rx_sr, sd_cmd_in};
    assign rx_last       = (type_q == RESP_LONG) ? (bit_cnt == 8'(LONG_LEN - 1))
                                                 : (bit_cnt == 8'(SHORT_LEN - 1));
    // Bits 40..46 of the frame carry crc[6]..crc[0].
    assign crc_idx       = 3'd6 - bit_cnt[2:0];

    assign tx_crc_en = (state == ST_SEND) && fall_en && (bit_cnt < 8'(CRC_BITS));
    assign rx_crc_en = (state == ST_RECV) && rise_en &&
                       ((type_q == RESP_LONG) ? (bit_cnt >= 8'd8 && bit_cnt <= 8'd127)
                                              : (bit_cnt < 8'(CRC_BITS)));

    sd_crc7 u_tx_crc (
        .clk    (ex_clk),
        .resetn (ex_resetn),
        .clr    (accept),
        .en     (tx_crc_en),
        .din    (tx_sr[39]),
        .crc    (tx_crc)
    );

    sd_crc7 u_rx_crc (
        .clk    (ex_clk),
        .resetn (ex_resetn),
        .clr    (accept),
        .en     (rx_crc_en),
        .din    (sd_cmd_in),
        .crc    (rx_crc)
    );

    always_ff @(posedge ex_clk) begin
        if (!ex_resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (accept) state_n = ST_SEND;
            ST_SEND: if (fall_en && bit_cnt == 8'(CMD_LEN))
                         state_n = (type_q == RESP_NONE) ? ST_GAP : ST_WAIT;
            ST_WAIT: if (rise_en) begin
                         if (!sd_cmd_in)
                             state_n = ST_RECV;
                         else if (wait_cnt == WAIT_W'(NCR_MAX - 1))
                             state_n = ST_GAP;
                     end
            ST_RECV: if (rise_en && rx_last) state_n = ST_GAP;
            ST_GAP:  if (rise_en && gap_cnt == GAP_W'(NCC - 1)) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge ex_clk) begin
        if (!ex_resetn) begin
            type_q         <= RESP_NONE;
            idx_q          <= '0;
            tx_sr          <= '0;
            rx_sr          <= '0;
            bit_cnt        <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            sd_cmd_out     <= 1'b1;
            sd_cmd_oe      <= 1'b0;
            cmd.resp_valid <= 1'b0;
            cmd.resp_data  <= '0;
            cmd.resp_err   <= '0;
        end else begin
            cmd.resp_valid <= 1'b0;
            case (state)
                ST_IDLE: if (accept) begin
                    type_q        <= resp_type_e'(cmd.resp_type);
                    idx_q         <= cmd.cmd_index;
                    tx_sr         <= {2'b01, cmd.cmd_index, cmd.cmd_arg};
                    bit_cnt       <= '0;
                    wait_cnt      <= '0;
                    gap_cnt       <= '0;
                    cmd.resp_data <= '0;
                    cmd.resp_err  <= '0;
                end
                ST_SEND: if (fall_en) begin
                    bit_cnt <= bit_cnt + 8'd1;
                    if (bit_cnt < 8'(CRC_BITS)) begin
                        sd_cmd_oe  <= 1'b1;
                        sd_cmd_out <= tx_sr[39];
                        tx_sr      <= {tx_sr[38:0], 1'b0};
                    end else if (bit_cnt < 8'(CMD_LEN - 1)) begin
                        sd_cmd_out <= tx_crc[crc_idx];
                    end else if (bit_cnt == 8'(CMD_LEN - 1)) begin
                        sd_cmd_out <= 1'b1;
                    end else begin
                        sd_cmd_oe  <= 1'b0;
                        sd_cmd_out <= 1'b1;
                        bit_cnt    <= '0;
                    end
                end
                ST_WAIT: if (rise_en) begin
                    if (!sd_cmd_in) begin
                        rx_sr   <= '0;
                        bit_cnt <= 8'd1;
                    end else if (wait_cnt == WAIT_W'(NCR_MAX - 1)) begin
                        cmd.resp_err[ERR_TIMEOUT] <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RECV: if (rise_en) begin
                    rx_sr   <= rx_next[126:0];
                    bit_cnt <= bit_cnt + 8'd1;
                    if (rx_last) begin
                        // rx_next holds the whole frame with the end bit at [0].
                        if (type_q == RESP_LONG) begin
                            cmd.resp_data         <= rx_next[127:1];
                            cmd.resp_err[ERR_CRC] <= (rx_crc != rx_next[7:1]);
                            cmd.resp_err[ERR_IDX] <= !rx_next[0];
                        end else begin
                            cmd.resp_data         <= {89'd0, rx_next[45:8]};
                            cmd.resp_err[ERR_CRC] <= (type_q == RESP_SHORT) &&
                                                     (rx_crc != rx_next[7:1]);
                            cmd.resp_err[ERR_IDX] <= !rx_next[0] ||
                                                     ((type_q == RESP_SHORT) &&
                                                      (rx_next[45:40] != idx_q));
                        end
                    end
                end
                ST_GAP: if (rise_en) begin
                    if (gap_cnt == GAP_W'(NCC - 1))
                        cmd.resp_valid <= 1'b1;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Directed bench for sd_cmd_engine: a simple card model captures TX frames on
// rising SD_CLK and drives replies on falling SD_CLK.
module tb_sd_cmd_engine;

    logic        ex_clk = 1'b0;
    logic        ex_resetn = 1'b0;
    logic [15:0] clk_div = 16'd3;
    logic        sd_clk, sd_cmd_out, sd_cmd_oe;
    logic        sd_cmd_in = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    sd_cmd_engine_if bus ();

    sd_cmd_engine #(.DIV_W(16), .NCR_MAX(64), .NCC(8)) dut (
        .ex_clk     (ex_clk),
        .ex_resetn  (ex_resetn),
        .clk_div    (clk_div),
        .cmd        (bus),
        .sd_clk     (sd_clk),
        .sd_cmd_out (sd_cmd_out),
        .sd_cmd_oe  (sd_cmd_oe),
        .sd_cmd_in  (sd_cmd_in)
    );

    always #5 ex_clk = ~ex_clk;

    task automatic check(input string tag, input string what,
                         input logic [135:0] obs, input logic [135:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    function automatic logic [6:0] crc7_of(logic [119:0] d, int n);
        logic [6:0] c;
        logic fb;
        c = '0;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [47:0] build_cmd(logic [5:0] idx, logic [31:0] arg);
        logic [39:0] h;
        h = {2'b01, idx, arg};
        return {h, crc7_of({80'd0, h}, 40), 1'b1};
    endfunction

    // Bounded wait for sd_clk to reach lvl; returns #1 after that ex_clk edge.
    task automatic wait_sd(input logic lvl);
        logic prev;
        prev = sd_clk;
        for (int i = 0; i < 400; i++) begin
            @(posedge ex_clk); #1;
            if (prev !== lvl && sd_clk === lvl) return;
            prev = sd_clk;
        end
        n_cmp++;
        n_bad++;
        $error("FAIL sd_clk_edge: observed no edge expected level %0d", lvl);
    endtask

    task automatic issue(input string tag, input logic [5:0] idx,
                         input logic [31:0] arg, input logic [1:0] typ);
        @(negedge ex_clk);
        check(tag, "ready_idle", bus.cmd_ready, 1);
        bus.cmd_index = idx;
        bus.cmd_arg   = arg;
        bus.resp_type = typ;
        bus.cmd_valid = 1'b1;
        @(posedge ex_clk); #1;
        bus.cmd_valid = 1'b0;
        check(tag, "ready_busy", bus.cmd_ready, 0);
    endtask

    task automatic capture(input string tag, output logic [47:0] fr);
        fr = '0;
        for (int i = 0; i < 10; i++) begin
            wait_sd(1'b1);
            if (sd_cmd_oe === 1'b1) break;
        end
        fr = {47'd0, sd_cmd_out};
        for (int i = 1; i < 48; i++) begin
            wait_sd(1'b1);
            fr = {fr[46:0], sd_cmd_out};
        end
        wait_sd(1'b0);
        check(tag, "oe_release", sd_cmd_oe, 0);
    endtask

    task automatic reply(input logic [135:0] rsp, input int n);
        repeat (2) wait_sd(1'b0);
        for (int i = n - 1; i >= 0; i--) begin
            sd_cmd_in = rsp[i];
            wait_sd(1'b0);
        end
        sd_cmd_in = 1'b1;
    endtask

    task automatic txn(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                       input logic [1:0] typ, input logic [47:0] exp_tx,
                       input logic [135:0] rsp, input int rsp_n,
                       input logic [126:0] exp_data, input logic [2:0] exp_err,
                       input int exp_lat, input bit poke);
        logic [47:0] fr;
        int lat;
        bit got;
        logic prev;
        int oe_hits;
        issue(tag, idx, arg, typ);
        if (poke) begin
            @(negedge ex_clk);
            bus.cmd_index = 6'd5;
            bus.cmd_arg   = 32'hDEADBEEF;
            bus.cmd_valid = 1'b1;
            @(negedge ex_clk);
            bus.cmd_valid = 1'b0;
        end
        capture(tag, fr);
        check(tag, "tx_frame", fr, exp_tx);
        if (rsp_n > 0) reply(rsp, rsp_n);
        lat  = 0;
        got  = 1'b0;
        prev = sd_clk;
        for (int i = 0; i < 3000; i++) begin
            @(posedge ex_clk); #1;
            if (!prev && sd_clk) lat++;
            prev = sd_clk;
            if (bus.resp_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        check(tag, "resp_valid_seen", got, 1);
        check(tag, "latency_rises", lat, exp_lat);
        check(tag, "ready_with_valid", bus.cmd_ready, 1);
        check(tag, "resp_data", bus.resp_data, exp_data);
        check(tag, "resp_err", bus.resp_err, exp_err);
        @(posedge ex_clk); #1;
        check(tag, "valid_one_cycle", bus.resp_valid, 0);
        if (poke) begin
            oe_hits = 0;
            for (int i = 0; i < 100; i++) begin
                @(posedge ex_clk); #1;
                if (sd_cmd_oe !== 1'b0) oe_hits++;
            end
            check(tag, "no_queued_cmd", oe_hits, 0);
        end
    endtask

    initial begin
        logic [119:0] cid;
        logic [6:0]   cid_crc;
        logic [39:0]  r9_hdr;
        logic [47:0]  r9;
        int           hits;

        bus.cmd_valid = 1'b0;
        bus.cmd_index = '0;
        bus.cmd_arg   = '0;
        bus.resp_type = '0;

        repeat (3) @(posedge ex_clk);
        #1;
        check("reset", "sd_clk", sd_clk, 0);
        check("reset", "cmd_oe", sd_cmd_oe, 0);
        check("reset", "cmd_out", sd_cmd_out, 1);
        check("reset", "cmd_ready", bus.cmd_ready, 1);
        check("reset", "resp_valid", bus.resp_valid, 0);
        check("reset", "resp_data", bus.resp_data, 0);
        check("reset", "resp_err", bus.resp_err, 0);
        @(negedge ex_clk);
        ex_resetn = 1'b1;

        // CMD0, no response, with an ignored cmd_valid pulse while busy.
        txn("cmd0", 6'd0, 32'h0, 2'd0, 48'h400000000095, '0, 0, '0, 3'b000, 8, 1'b1);

        // CMD8 good R7, then injected errors.
        txn("cmd8_ok", 6'd8, 32'h1AA, 2'd1, 48'h48000001AA87,
            136'h08000001AA13, 48, 127'h08000001AA, 3'b000, 8, 1'b0);
        txn("cmd8_crc", 6'd8, 32'h1AA, 2'd1, 48'h48000001AA87,
            136'h08000001AA11, 48, 127'h08000001AA, 3'b010, 8, 1'b0);
        r9_hdr = {2'b00, 6'd9, 32'h1AA};
        r9     = {r9_hdr, crc7_of({80'd0, r9_hdr}, 40), 1'b1};
        txn("cmd8_idx", 6'd8, 32'h1AA, 2'd1, 48'h48000001AA87,
            {88'd0, r9}, 48, 127'h09000001AA, 3'b100, 8, 1'b0);
        txn("cmd8_end", 6'd8, 32'h1AA, 2'd1, 48'h48000001AA87,
            136'h08000001AA12, 48, 127'h08000001AA, 3'b100, 8, 1'b0);
        txn("cmd8_crc_end", 6'd8, 32'h1AA, 2'd1, 48'h48000001AA87,
            136'h08000001AA10, 48, 127'h08000001AA, 3'b110, 8, 1'b0);

        // R3: index field 111111 and all-ones CRC field are not checked.
        txn("r3", 6'd41, 32'h40FF8000, 2'd2, build_cmd(6'd41, 32'h40FF8000),
            136'h3F80FF8000FF, 48, 127'h3F80FF8000, 3'b000, 8, 1'b0);

        // No start bit: 64 wait rises plus 8 gap rises.
        txn("timeout", 6'd8, 32'h1AA, 2'd1, 48'h48000001AA87,
            '0, 0, '0, 3'b001, 72, 1'b0);

        // R2 with a CID payload at two divider settings.
        cid     = 120'h0353445344333247801A2B3C4D0145;
        cid_crc = crc7_of(cid, 120);
        txn("r2_div3", 6'd2, 32'h0, 2'd3, build_cmd(6'd2, 32'h0),
            {2'b00, 6'h3F, cid, cid_crc, 1'b1}, 136, {cid, cid_crc}, 3'b000, 8, 1'b0);
        @(negedge ex_clk);
        clk_div = 16'd0;
        txn("r2_div0", 6'd2, 32'h0, 2'd3, build_cmd(6'd2, 32'h0),
            {2'b00, 6'h3F, cid, cid_crc, 1'b1}, 136, {cid, cid_crc}, 3'b000, 8, 1'b0);
        @(negedge ex_clk);
        clk_div = 16'd3;

        // Reset in the middle of SEND aborts without a response strobe.
        issue("abort", 6'd17, 32'h12345678, 2'd1);
        repeat (10) wait_sd(1'b1);
        check("abort", "oe_mid_send", sd_cmd_oe, 1);
        @(negedge ex_clk);
        ex_resetn = 1'b0;
        @(posedge ex_clk); #1;
        check("abort", "cmd_oe", sd_cmd_oe, 0);
        check("abort", "cmd_ready", bus.cmd_ready, 1);
        check("abort", "sd_clk", sd_clk, 0);
        check("abort", "cmd_out", sd_cmd_out, 1);
        @(negedge ex_clk);
        ex_resetn = 1'b1;
        hits = 0;
        for (int i = 0; i < 1500; i++) begin
            @(posedge ex_clk); #1;
            if (bus.resp_valid !== 1'b0 || sd_cmd_oe !== 1'b0) hits++;
        end
        check("abort", "no_resp_after_abort", hits, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
